// File: rtl/cpu_sram_responder.sv
// Shared-word SRAM responder for the core's instruction and data ports, with a post-reset clear sweep.
// Optional macro SRAM_BYPASS_EN selects write-first forwarding; the default build is read-first.
module cpu_sram_responder #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [31:0]         inst_rdata_q, inst_rdata_d;
  logic [31:0]         data_rdata_q, data_rdata_d;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   inst_idx, data_idx;
  logic                inst_wr, data_wr;
  logic [31:0]         inst_view, data_view;
  logic                unused_addr_bits;

  assign inst_idx = inst_sram_addr[ADDR_W+1:2];
  assign data_idx = data_sram_addr[ADDR_W+1:2];
  // Byte offset and bits above the array are don't-care: high addresses alias.
  assign unused_addr_bits = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                              data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  assign inst_wr = (state_q == READY) && inst_sram_en && (|inst_sram_wen);
  assign data_wr = (state_q == READY) && data_sram_en && (|data_sram_wen);

  always_comb begin
    inst_view = mem[inst_idx];
    data_view = mem[data_idx];
`ifdef SRAM_BYPASS_EN
    // Forward the merged post-write word; data lanes applied last so they win.
    if (inst_wr && (inst_idx == inst_idx))
      inst_view = lane_merge(inst_view, inst_sram_wdata, inst_sram_wen);
    if (data_wr && (data_idx == inst_idx))
      inst_view = lane_merge(inst_view, data_sram_wdata, data_sram_wen);
    if (inst_wr && (inst_idx == data_idx))
      data_view = lane_merge(data_view, inst_sram_wdata, inst_sram_wen);
    if (data_wr && (data_idx == data_idx))
      data_view = lane_merge(data_view, data_sram_wdata, data_sram_wen);
`endif
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = READY;
      end
      READY: begin
        if (inst_sram_en) inst_rdata_d = inst_view;
        if (data_sram_en) data_rdata_d = data_view;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Array storage is never reset; the sweep owns it until READY.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= INIT_VAL;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (inst_wr && inst_sram_wen[b]) mem[inst_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
        if (data_wr && data_sram_wen[b]) mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign init_done       = (state_q == READY);

endmodule
